// File: rtl/id_ex_reg.sv
// id_ex_reg: decode-to-execute pipeline register of the 5-stage MIPS core.
// Registers the D-stage operands, immediate, register numbers, PC, instruction
// and Tnew for the E stage. It supports hold, bubble insertion and a
// free-running count of inserted bubbles.
// Optional build macro: ID_EX_HOLD_FWD_EN. When it is defined, operands held
// during a stall are refreshed from the W-stage write port.
module id_ex_reg #(
  parameter logic [31:0] RESET_PC = 32'h00003000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hold,
  input  logic        flush,
  input  logic [31:0] d_pc,
  input  logic [31:0] d_instr,
  input  logic [31:0] d_rs_data,
  input  logic [31:0] d_rt_data,
  input  logic [31:0] d_ext,
  input  logic [4:0]  d_rs_addr,
  input  logic [4:0]  d_rt_addr,
  input  logic [4:0]  d_wr_addr,
  input  logic [1:0]  d_tnew,
  input  logic        fwd_we,
  input  logic [4:0]  fwd_addr,
  input  logic [31:0] fwd_data,
  output logic [31:0] e_pc,
  output logic [31:0] e_instr,
  output logic [31:0] e_rs_data,
  output logic [31:0] e_rt_data,
  output logic [31:0] e_ext,
  output logic [4:0]  e_rs_addr,
  output logic [4:0]  e_rt_addr,
  output logic [4:0]  e_wr_addr,
  output logic [1:0]  e_tnew,
  output logic        e_valid,
  output logic [31:0] bubble_cnt
);

`ifdef ID_EX_HOLD_FWD_EN
  // A held instruction picks up W-stage results for its sources. $0 is
  // never refreshed.
  logic fwd_rs_hit;
  logic fwd_rt_hit;
  assign fwd_rs_hit = e_valid && fwd_we && (fwd_addr != 5'd0) && (fwd_addr == e_rs_addr);
  assign fwd_rt_hit = e_valid && fwd_we && (fwd_addr != 5'd0) && (fwd_addr == e_rt_addr);
`else
  // With the feature off, the fwd_* ports are unused.
  logic unused_fwd;
  assign unused_fwd = ^{fwd_we, fwd_addr, fwd_data};
`endif

  // Pipeline fields: the priority is reset, then hold, then flush, then load.
  always_ff @(posedge clk) begin
    if (!reset) begin
      e_pc      <= RESET_PC;
      e_instr   <= '0;
      e_rs_data <= '0;
      e_rt_data <= '0;
      e_ext     <= '0;
      e_rs_addr <= '0;
      e_rt_addr <= '0;
      e_wr_addr <= '0;
      e_tnew    <= '0;
      e_valid   <= 1'b0;
    end else if (hold) begin
`ifdef ID_EX_HOLD_FWD_EN
      if (fwd_rs_hit) e_rs_data <= fwd_data;
      if (fwd_rt_hit) e_rt_data <= fwd_data;
`endif
    end else if (flush) begin
      // A bubble keeps the PC and encodes "sll $0,$0,0" with no destination.
      e_pc      <= d_pc;
      e_instr   <= '0;
      e_rs_data <= '0;
      e_rt_data <= '0;
      e_ext     <= '0;
      e_rs_addr <= '0;
      e_rt_addr <= '0;
      e_wr_addr <= '0;
      e_tnew    <= '0;
      e_valid   <= 1'b0;
    end else begin
      e_pc      <= d_pc;
      e_instr   <= d_instr;
      e_rs_data <= d_rs_data;
      e_rt_data <= d_rt_data;
      e_ext     <= d_ext;
      e_rs_addr <= d_rs_addr;
      e_rt_addr <= d_rt_addr;
      e_wr_addr <= d_wr_addr;
      e_tnew    <= d_tnew;
      e_valid   <= 1'b1;
    end
  end

  // Bubble counter for performance debug. It wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (!reset) begin
      bubble_cnt <= '0;
    end else if (!hold && flush) begin
      bubble_cnt <= bubble_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_id_ex_reg.sv
// tb_id_ex_reg: directed and random stimulus for id_ex_reg. A reference model
// computes the expected output state for each edge. That state is queued when
// the stimulus is driven and is popped and compared once the DUT updates.
module tb_id_ex_reg;
  logic        clk = 1'b0;
  logic        reset, hold, flush;
  logic [31:0] d_pc, d_instr, d_rs_data, d_rt_data, d_ext;
  logic [4:0]  d_rs_addr, d_rt_addr, d_wr_addr;
  logic [1:0]  d_tnew;
  logic        fwd_we;
  logic [4:0]  fwd_addr;
  logic [31:0] fwd_data;
  logic [31:0] e_pc, e_instr, e_rs_data, e_rt_data, e_ext;
  logic [4:0]  e_rs_addr, e_rt_addr, e_wr_addr;
  logic [1:0]  e_tnew;
  logic        e_valid;
  logic [31:0] bubble_cnt;

  typedef struct packed {
    logic [31:0] pc, instr, rs, rt, ext;
    logic [4:0]  rsa, rta, wra;
    logic [1:0]  tnew;
    logic        valid;
    logic [31:0] bcnt;
  } exp_t;

  exp_t q[$];
  exp_t m;
  int n_assert = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  id_ex_reg dut (
    .clk(clk), .reset(reset), .hold(hold), .flush(flush),
    .d_pc(d_pc), .d_instr(d_instr), .d_rs_data(d_rs_data), .d_rt_data(d_rt_data),
    .d_ext(d_ext), .d_rs_addr(d_rs_addr), .d_rt_addr(d_rt_addr), .d_wr_addr(d_wr_addr),
    .d_tnew(d_tnew), .fwd_we(fwd_we), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .e_pc(e_pc), .e_instr(e_instr), .e_rs_data(e_rs_data), .e_rt_data(e_rt_data),
    .e_ext(e_ext), .e_rs_addr(e_rs_addr), .e_rt_addr(e_rt_addr), .e_wr_addr(e_wr_addr),
    .e_tnew(e_tnew), .e_valid(e_valid), .bubble_cnt(bubble_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rand_d();
    d_pc      = $urandom;
    d_instr   = $urandom;
    d_rs_data = $urandom;
    d_rt_data = $urandom;
    d_ext     = $urandom;
    d_rs_addr = 5'($urandom);
    d_rt_addr = 5'($urandom);
    d_wr_addr = 5'($urandom);
    d_tnew    = 2'($urandom);
  endtask

  // Drive one cycle, predict the result, then compare it after the edge.
  task automatic step(input logic r, input logic h, input logic f);
    exp_t e;
    reset = r;
    hold  = h;
    flush = f;
    if (!r) begin
      m = '0;
      m.pc = 32'h00003000;
    end else if (h) begin
`ifdef ID_EX_HOLD_FWD_EN
      if (m.valid && fwd_we && fwd_addr != 5'd0) begin
        if (fwd_addr == m.rsa) m.rs = fwd_data;
        if (fwd_addr == m.rta) m.rt = fwd_data;
      end
`endif
    end else if (f) begin
      m.pc = d_pc; m.instr = '0; m.rs = '0; m.rt = '0; m.ext = '0;
      m.rsa = '0; m.rta = '0; m.wra = '0; m.tnew = '0; m.valid = 1'b0;
      m.bcnt = m.bcnt + 32'd1;
    end else begin
      m.pc = d_pc; m.instr = d_instr; m.rs = d_rs_data; m.rt = d_rt_data;
      m.ext = d_ext; m.rsa = d_rs_addr; m.rta = d_rt_addr; m.wra = d_wr_addr;
      m.tnew = d_tnew; m.valid = 1'b1;
    end
    q.push_back(m);
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk("e_pc", e_pc, e.pc);
    chk("e_instr", e_instr, e.instr);
    chk("e_rs_data", e_rs_data, e.rs);
    chk("e_rt_data", e_rt_data, e.rt);
    chk("e_ext", e_ext, e.ext);
    chk("e_rs_addr", 32'(e_rs_addr), 32'(e.rsa));
    chk("e_rt_addr", 32'(e_rt_addr), 32'(e.rta));
    chk("e_wr_addr", 32'(e_wr_addr), 32'(e.wra));
    chk("e_tnew", 32'(e_tnew), 32'(e.tnew));
    chk("e_valid", 32'(e_valid), 32'(e.valid));
    chk("bubble_cnt", bubble_cnt, e.bcnt);
  endtask

  initial begin
    m = '0;
    fwd_we = 1'b0; fwd_addr = '0; fwd_data = '0;
    reset = 1'b0; hold = 1'b0; flush = 1'b0;
    rand_d();
    @(negedge clk);

    // Reset for two cycles while the inputs are random.
    step(1'b0, 1'b1, 1'b1);
    rand_d();
    step(1'b0, 1'b0, 1'b0);
    chk("reset_pc_const", e_pc, 32'h00003000);
    chk("reset_valid_const", 32'(e_valid), 32'd0);

    // Load a real instruction.
    rand_d();
    d_pc = 32'h00003004; d_ext = 32'hFFFF8000; d_wr_addr = 5'd8; d_tnew = 2'd2;
    step(1'b1, 1'b0, 1'b0);
    chk("load_ext_const", e_ext, 32'hFFFF8000);
    chk("load_wr_const", 32'(e_wr_addr), 32'd8);
    chk("load_valid_const", 32'(e_valid), 32'd1);

    // Flush, then two more consecutive flushes.
    d_pc = 32'h00003010; d_instr = 32'h8C280004;
    step(1'b1, 1'b0, 1'b1);
    chk("flush_pc_const", e_pc, 32'h00003010);
    chk("flush_cnt1_const", bubble_cnt, 32'd1);
    rand_d(); step(1'b1, 1'b0, 1'b1);
    rand_d(); step(1'b1, 1'b0, 1'b1);
    chk("flush_cnt3_const", bubble_cnt, 32'd3);

    // Hold has priority over flush.
    rand_d(); d_ext = 32'h0000ABCD;
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      rand_d();
      step(1'b1, 1'b1, 1'b1);
    end
    chk("hold_ext_const", e_ext, 32'h0000ABCD);
    chk("hold_cnt_const", bubble_cnt, 32'd3);
    rand_d(); step(1'b1, 1'b0, 1'b1);
    chk("unhold_cnt_const", bubble_cnt, 32'd4);

    // Refresh a held operand from the W stage.
    rand_d(); d_rs_addr = 5'd9; d_rt_addr = 5'd9;
    d_rs_data = 32'h11111111; d_rt_data = 32'h22222222;
    step(1'b1, 1'b0, 1'b0);
    fwd_we = 1'b1; fwd_addr = 5'd9; fwd_data = 32'h12345678;
    rand_d(); step(1'b1, 1'b1, 1'b0);
`ifdef ID_EX_HOLD_FWD_EN
    chk("fwd_rs_const", e_rs_data, 32'h12345678);
    chk("fwd_rt_const", e_rt_data, 32'h12345678);
`else
    chk("nofwd_rs_const", e_rs_data, 32'h11111111);
    chk("nofwd_rt_const", e_rt_data, 32'h22222222);
`endif
    fwd_addr = 5'd0; fwd_data = 32'hDEADBEEF;
    rand_d(); step(1'b1, 1'b1, 1'b0);
    // Forwarding into a single operand: only rs matches.
    rand_d(); d_rs_addr = 5'd3; d_rt_addr = 5'd9;
    fwd_we = 1'b0;
    step(1'b1, 1'b0, 1'b0);
    fwd_we = 1'b1; fwd_addr = 5'd3; fwd_data = 32'hCAFEF00D;
    rand_d(); step(1'b1, 1'b1, 1'b0);
    fwd_we = 1'b0;
    rand_d(); step(1'b1, 1'b1, 1'b0);

    // Reset arrives in the middle of a hold.
    rand_d(); step(1'b0, 1'b1, 1'b0);
    chk("midhold_pc_const", e_pc, 32'h00003000);
    chk("midhold_cnt_const", bubble_cnt, 32'd0);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      rand_d();
      fwd_we   = 1'($urandom);
      fwd_addr = 5'($urandom_range(0, 3));
      fwd_data = $urandom;
      d_rs_addr = 5'($urandom_range(0, 3));
      d_rt_addr = 5'($urandom_range(0, 3));
      step(($urandom_range(0, 19) != 0), 1'($urandom), 1'($urandom));
    end

    n_assert++;
    assert (q.size() == 0) else begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed %0d expected 0", q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
